drec_sdram_arbiter: RTL and testbench

- Single-port scheduler between the recorder controller and the SDRAM core.
- Captures one-cycle write pulses (record path) and read pulses (play path) into one-deep pending slots.
- Arbitrates the slots round-robin, drives the core's req/ack handshake, and returns read data over an rdy/ack handshake.
- Guards against lost requests (overrun) and a hung core (timeout).

---
 rtl/drec_sdram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_drec_sdram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drec_sdram_arbiter.sv
// Recorder-to-SDRAM scheduler: one-deep write/read slots, round-robin
// grant, core req/ack handshake, read return over rdy/ack.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_enable/addr/data write request pulse and its payload
//   rd_enable/addr      read request pulse and its address
//   rd_data/_rdy/_ack   returned sample, held until acknowledged
//   mem_req/we/addr/    request to the SDRAM core
//   mem_wdata/ack
//   mem_rdata/rvalid    read return from the core (one-cycle strobe)
//   busy                FSM active or any slot pending
//   err_overrun         sticky: pending request overwritten
//   err_timeout         sticky: transaction aborted on timeout
module drec_sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_rdy,
  input  logic              rd_data_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              last_w_q, last_w_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_timeout_q, err_timeout_d;
  logic              wr_retire, rd_retire;

  always_comb begin
    state_d       = state_q;
    wr_pend_d     = wr_pend_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_pend_d     = rd_pend_q;
    rd_addr_d     = rd_addr_q;
    last_w_d      = last_w_q;
    cnt_d         = cnt_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rd_data_d     = rd_data_q;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;
    wr_retire     = 1'b0;
    rd_retire     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Write wins unless a read is also pending and write went last.
        if (wr_pend_q && (!rd_pend_q || !last_w_q)) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = wr_data_q;
          last_w_d    = 1'b1;
          cnt_d       = '0;
          state_d     = ISSUE;
        end else if (rd_pend_q) begin
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr_q;
          last_w_d   = 1'b0;
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ack) begin
          wr_retire = mem_we_q;
          rd_retire = !mem_we_q;
          cnt_d     = '0;
          state_d   = mem_we_q ? IDLE : WAIT_RD;
        end else if (cnt_q == CNT_LAST) begin
          wr_retire     = mem_we_q;
          rd_retire     = !mem_we_q;
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          rd_data_d = mem_rdata;
          state_d   = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      HOLD: begin
        if (rd_data_ack) state_d = IDLE;
      end
    endcase

    // A capture in the retire cycle survives as the next request.
    if (wr_retire) wr_pend_d = 1'b0;
    if (wr_enable) begin
      if (wr_pend_q && !wr_retire) err_overrun_d = 1'b1;
      wr_pend_d = 1'b1;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
    end

    if (rd_retire) rd_pend_d = 1'b0;
    if (rd_enable) begin
      if (rd_pend_q && !rd_retire) err_overrun_d = 1'b1;
      rd_pend_d = 1'b1;
      rd_addr_d = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      last_w_q      <= 1'b0;
      cnt_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_data_q     <= '0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_pend_q     <= wr_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_pend_q     <= rd_pend_d;
      rd_addr_q     <= rd_addr_d;
      last_w_q      <= last_w_d;
      cnt_q         <= cnt_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_data_q     <= rd_data_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign mem_req     = (state_q == ISSUE);
  assign rd_data_rdy = (state_q == HOLD);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rd_data     = rd_data_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != IDLE) || wr_pend_q || rd_pend_q;

endmodule

// File: tb/tb_drec_sdram_arbiter.sv
// Directed bench for drec_sdram_arbiter (TIMEOUT=8).
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_drec_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_enable = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_enable = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_data_rdy;
  logic        rd_data_ack = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        busy;
  logic        err_overrun;
  logic        err_timeout;

  int pass_cnt = 0;
  int total = 0;

  drec_sdram_arbiter #(
    .ADDR_W(24), .DATA_W(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enable(rd_enable), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_rdy(rd_data_rdy),
    .rd_data_ack(rd_data_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    rst = 1'b0;
    total++;
    if ({mem_req, mem_we, rd_data_rdy, busy} !== 4'b0000)
      $display("FAIL rst_ctrl got %b want 0000", {mem_req, mem_we, rd_data_rdy, busy});
    else pass_cnt++;
    total++;
    if ({mem_addr, mem_wdata, rd_data} !== 56'h0)
      $display("FAIL rst_data got %h want 0", {mem_addr, mem_wdata, rd_data});
    else pass_cnt++;
    total++;
    if ({err_overrun, err_timeout} !== 2'b00)
      $display("FAIL rst_err got %b want 00", {err_overrun, err_timeout});
    else pass_cnt++;
  endtask

  task automatic test_write();
    wr_enable = 1'b1; wr_addr = 24'h000010; wr_data = 16'hBEEF;
    step();
    wr_enable = 1'b0;
    total++;
    if ({mem_req, busy} !== 2'b01)
      $display("FAIL wr_n1 req/busy got %b want 01", {mem_req, busy});
    else pass_cnt++;
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 24'h000010, 16'hBEEF})
        $display("FAIL wr_issue%0d got %b %b %h %h want 1 1 000010 beef", i, mem_req, mem_we, mem_addr, mem_wdata);
      else pass_cnt++;
      if (i == 2) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    total++;
    if ({mem_req, busy} !== 2'b00)
      $display("FAIL wr_done req/busy got %b want 00", {mem_req, busy});
    else pass_cnt++;
  endtask

  task automatic test_read();
    rd_enable = 1'b1; rd_addr = 24'h000005;
    step();
    rd_enable = 1'b0;
    step();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 24'h000005})
      $display("FAIL rd_issue got %b %b %h want 1 0 000005", mem_req, mem_we, mem_addr);
    else pass_cnt++;
    step();
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++;
    if ({mem_req, busy} !== 2'b01)
      $display("FAIL rd_wait req/busy got %b want 01", {mem_req, busy});
    else pass_cnt++;
    step();
    step();
    total++;
    if (rd_data_rdy !== 1'b0)
      $display("FAIL rd_early_rdy got %b want 0", rd_data_rdy);
    else pass_cnt++;
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_rvalid = 1'b0; mem_rdata = 16'h0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rd_data_rdy, rd_data} !== {1'b1, 16'h1234})
        $display("FAIL rd_hold%0d got %b %h want 1 1234", i, rd_data_rdy, rd_data);
      else pass_cnt++;
      if (i == 3) rd_data_ack = 1'b1;
      step();
    end
    rd_data_ack = 1'b0;
    total++;
    if ({rd_data_rdy, busy} !== 2'b00)
      $display("FAIL rd_release rdy/busy got %b want 00", {rd_data_rdy, busy});
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    wr_enable = 1'b1; wr_addr = 24'h1; wr_data = 16'hAAAA;
    rd_enable = 1'b1; rd_addr = 24'h2;
    step();
    wr_enable = 1'b0; rd_enable = 1'b0;
    step();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b11, 24'h1})
      $display("FAIL sim1_first got %b %b %h want 1 1 000001", mem_req, mem_we, mem_addr);
    else pass_cnt++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 24'h2})
      $display("FAIL sim1_second got %b %b %h want 1 0 000002", mem_req, mem_we, mem_addr);
    else pass_cnt++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0; rd_data_ack = 1'b1;
    step();
    rd_data_ack = 1'b0;
    wr_enable = 1'b1; wr_addr = 24'h3; wr_data = 16'h3333;
    step();
    wr_enable = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    wr_enable = 1'b1; wr_addr = 24'h4; wr_data = 16'h4444;
    rd_enable = 1'b1; rd_addr = 24'h5;
    step();
    wr_enable = 1'b0; rd_enable = 1'b0;
    step();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 24'h5})
      $display("FAIL sim2_first got %b %b %h want 1 0 000005", mem_req, mem_we, mem_addr);
    else pass_cnt++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0; rd_data_ack = 1'b1;
    step();
    rd_data_ack = 1'b0;
    step();
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 24'h4, 16'h4444})
      $display("FAIL sim2_second got %b %b %h %h want 1 1 000004 4444", mem_req, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++;
    if (busy !== 1'b0)
      $display("FAIL sim_idle busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int wcnt;
    do_reset();
    rd_enable = 1'b1; rd_addr = 24'h6;
    step();
    rd_enable = 1'b0;
    step();
    wr_enable = 1'b1; wr_addr = 24'h7; wr_data = 16'h1111;
    step();
    wr_addr = 24'h8; wr_data = 16'h2222;
    total++;
    if (err_overrun !== 1'b0)
      $display("FAIL ovr_early got %b want 0", err_overrun);
    else pass_cnt++;
    step();
    wr_enable = 1'b0;
    total++;
    if (err_overrun !== 1'b1)
      $display("FAIL ovr_flag got %b want 1", err_overrun);
    else pass_cnt++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0; rd_data_ack = 1'b1;
    step();
    rd_data_ack = 1'b0;
    step();
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 24'h8, 16'h2222})
      $display("FAIL ovr_write got %b %b %h %h want 1 1 000008 2222", mem_req, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req && mem_we) wcnt++;
      step();
    end
    total++;
    if ({wcnt, busy} !== {32'd0, 1'b0})
      $display("FAIL ovr_single extra_writes=%0d busy=%b want 0 0", wcnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int rcnt;
    wr_enable = 1'b1; wr_addr = 24'h9; wr_data = 16'h9999;
    step();
    wr_enable = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (mem_req) rcnt++;
    end
    total++;
    if (rcnt !== 8)
      $display("FAIL to_req_cycles got %0d want 8", rcnt);
    else pass_cnt++;
    total++;
    if ({err_timeout, busy} !== 2'b10)
      $display("FAIL to_flag err/busy got %b want 10", {err_timeout, busy});
    else pass_cnt++;
    wr_enable = 1'b1; wr_addr = 24'hA; wr_data = 16'hAAAA;
    step();
    wr_enable = 1'b0;
    step();
    total++;
    if ({mem_req, mem_we, mem_wdata} !== {2'b11, 16'hAAAA})
      $display("FAIL to_next_issue got %b %b %h want 1 1 aaaa", mem_req, mem_we, mem_wdata);
    else pass_cnt++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++;
    if ({mem_req, busy, err_timeout} !== 3'b001)
      $display("FAIL to_next_done req/busy/err got %b want 001", {mem_req, busy, err_timeout});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    rd_enable = 1'b1; rd_addr = 24'hB;
    step();
    rd_enable = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++;
    if ({busy, mem_req, err_overrun, err_timeout} !== 4'b1011)
      $display("FAIL rmr_pre got %b want 1011", {busy, mem_req, err_overrun, err_timeout});
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({mem_req, mem_we, rd_data_rdy, busy, err_overrun, err_timeout} !== 6'b0)
      $display("FAIL rmr_ctrl got %b want 000000", {mem_req, mem_we, rd_data_rdy, busy, err_overrun, err_timeout});
    else pass_cnt++;
    total++;
    if ({mem_addr, mem_wdata, rd_data} !== 56'h0)
      $display("FAIL rmr_data got %h want 0", {mem_addr, mem_wdata, rd_data});
    else pass_cnt++;
    mem_rvalid = 1'b1; mem_rdata = 16'h5555;
    step();
    mem_rvalid = 1'b0; mem_rdata = 16'h0;
    total++;
    if ({rd_data_rdy, rd_data} !== 17'h0)
      $display("FAIL rmr_stray got %b %h want 0 0000", rd_data_rdy, rd_data);
    else pass_cnt++;
    step();
    total++;
    if ({rd_data_rdy, busy} !== 2'b00)
      $display("FAIL rmr_idle got %b want 00", {rd_data_rdy, busy});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_overrun();
    test_timeout();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
